// File: rtl/sha1_msg_schedule.sv
// -----------------------------------------------------------------------------
// sha1_msg_schedule
//
// Word-serial SHA-1 message-schedule expander. Accepts one padded 512-bit
// block as sixteen 32-bit big-endian words, expands them in place to the full
// 80-word schedule W[0..79] at one word per cycle, then holds the array
// stable until the downstream rounds stage releases it.
//
// Ports:
//   clk             sole clock, rising edge
//   rst_n           asynchronous active-low reset
//   i_in_valid      i_in_word carries a valid message word this cycle
//   i_in_word[31:0] message word; first accepted word is W[0]
//   o_in_ready      block can accept a word this cycle (LOAD state)
//   i_msg_release   single-cycle pulse from rounds stage: schedule consumed
//   o_msg[79:0]     schedule array, element t = W[t]
//   o_msg_valid     o_msg holds a complete, stable schedule (HOLD state)
// -----------------------------------------------------------------------------
module sha1_msg_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_in_valid,
    input  logic [31:0] i_in_word,
    output logic        o_in_ready,
    input  logic        i_msg_release,
    output logic [31:0] o_msg [79:0],
    output logic        o_msg_valid
);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t      r_state;
    logic [6:0]  r_t;
    logic [31:0] r_w [79:0];
    logic        r_in_ready;
    logic        r_msg_valid;

    logic [6:0]  w_idx3;
    logic [6:0]  w_idx8;
    logic [6:0]  w_idx14;
    logic [6:0]  w_idx16;
    logic [31:0] w_new;

    // One-bit left rotate of a 32-bit word.
    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    // Tap indices for the expansion recurrence. They are only meaningful in
    // EXPAND where t >= 16, so the wrap-around at small t is harmless.
    always_comb begin
        w_idx3  = r_t - 7'd3;
        w_idx8  = r_t - 7'd8;
        w_idx14 = r_t - 7'd14;
        w_idx16 = r_t - 7'd16;
        w_new   = rotl1(r_w[w_idx3] ^ r_w[w_idx8] ^ r_w[w_idx14] ^ r_w[w_idx16]);
    end

    // Control FSM, schedule storage and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_LOAD;
            r_t         <= 7'd0;
            r_in_ready  <= 1'b1;
            r_msg_valid <= 1'b0;
            for (int i = 0; i < 80; i++) begin
                r_w[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (i_in_valid) begin
                        r_w[r_t] <= i_in_word;
                        if (r_t == 7'd15) begin
                            r_state    <= ST_EXPAND;
                            r_t        <= 7'd16;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_t <= r_t + 7'd1;
                        end
                    end
                end
                ST_EXPAND: begin
                    // W[t-3] was written three cycles ago, so all taps are
                    // already registered and no bypass is required.
                    r_w[r_t] <= w_new;
                    if (r_t == 7'd79) begin
                        r_state     <= ST_HOLD;
                        r_t         <= 7'd0;
                        r_msg_valid <= 1'b1;
                    end else begin
                        r_t <= r_t + 7'd1;
                    end
                end
                ST_HOLD: begin
                    // Array is frozen; any word offered here is not accepted
                    // because o_in_ready is low.
                    if (i_msg_release) begin
                        r_state     <= ST_LOAD;
                        r_msg_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_LOAD;
                    r_t         <= 7'd0;
                    r_in_ready  <= 1'b1;
                    r_msg_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_msg       = r_w;
    assign o_in_ready  = r_in_ready;
    assign o_msg_valid = r_msg_valid;

endmodule

// File: tb/tb_sha1_msg_schedule.sv
module tb_sha1_msg_schedule;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_word;
    logic        in_ready;
    logic        msg_release;
    logic [31:0] msg [79:0];
    logic        msg_valid;

    int checks = 0;
    int errors = 0;

    logic [31:0] blk   [16];
    logic [31:0] exp_w [80];

    always #5 clk = ~clk;

    sha1_msg_schedule dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_in_valid    (in_valid),
        .i_in_word     (in_word),
        .o_in_ready    (in_ready),
        .i_msg_release (msg_release),
        .o_msg         (msg),
        .o_msg_valid   (msg_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference schedule straight from the SHA-1 recurrence.
    task automatic build_model();
        logic [31:0] x;
        for (int t = 0; t < 16; t++) exp_w[t] = blk[t];
        for (int t = 16; t < 80; t++) begin
            x = exp_w[t-3] ^ exp_w[t-8] ^ exp_w[t-14] ^ exp_w[t-16];
            exp_w[t] = (x << 1) | (x >> 31);
        end
    endtask

    task automatic rand_block();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
    endtask

    task automatic fill_block(input logic [31:0] v);
        for (int i = 0; i < 16; i++) blk[i] = v;
    endtask

    task automatic load_block(input logic [15:0] stall, output time t0, output time t15);
        t0 = 0;
        t15 = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_word  = blk[i];
            chk($sformatf("ready_w%0d", i), 32'(in_ready), 32'd1);
            @(posedge clk);
            if (i == 0)  t0  = $time;
            if (i == 15) t15 = $time;
            #1;
            in_valid = 1'b0;
            in_word  = 32'd0;
            if (stall[i]) repeat (3) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_valid(input time t15, input string tag);
        bit  seen = 1'b0;
        time tv   = 0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (msg_valid) begin
                seen = 1'b1;
                tv   = $time - 1;
            end
        end
        chk({tag, "_valid_seen"}, 32'(seen), 32'd1);
        if (seen) chk({tag, "_latency"}, 32'((tv - t15) / 10), 32'd64);
    endtask

    task automatic check_sched(input string tag);
        for (int t = 0; t < 80; t++)
            chk($sformatf("%s_w%0d", tag, t), msg[t], exp_w[t]);
    endtask

    task automatic release_now();
        msg_release = 1'b1;
        @(posedge clk);
        #1;
        msg_release = 1'b0;
    endtask

    task automatic run_block(input string tag, input logic [15:0] stall);
        time t0, t15;
        build_model();
        load_block(stall, t0, t15);
        chk({tag, "_ready_expand"}, 32'(in_ready), 32'd0);
        wait_valid(t15, tag);
        check_sched(tag);
        chk({tag, "_ready_hold"}, 32'(in_ready), 32'd0);
    endtask

    task automatic abc_block();
        fill_block(32'd0);
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    initial begin
        time t0a, t15a, t0b, t15b;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_word     = 32'd0;
        msg_release = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(msg_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_w0", msg[0], 32'd0);
        chk("rst_w79", msg[79], 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // "abc" block with known schedule words.
        abc_block();
        run_block("abc", 16'h0000);
        chk("abc_w16", msg[16], 32'hC2C4C700);
        chk("abc_w17", msg[17], 32'h00000000);
        chk("abc_w18", msg[18], 32'h00000030);
        chk("abc_w19", msg[19], 32'h85898E01);
        release_now();
        chk("abc_rel_ready", 32'(in_ready), 32'd1);
        chk("abc_rel_valid", 32'(msg_valid), 32'd0);

        // All-zero and all-ones blocks.
        fill_block(32'h00000000);
        run_block("zero", 16'h0000);
        chk("zero_w79", msg[79], 32'd0);
        release_now();
        fill_block(32'hFFFFFFFF);
        run_block("ones", 16'h0000);
        chk("ones_w16", msg[16], 32'h00000000);
        release_now();

        // Stalled load with a stray release during EXPAND.
        rand_block();
        build_model();
        load_block(16'h4081, t0a, t15a);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        release_now();
        chk("stray_valid", 32'(msg_valid), 32'd0);
        chk("stray_ready", 32'(in_ready), 32'd0);
        wait_valid(t15a, "stall");
        check_sched("stall");

        // HOLD ignores offered words.
        in_valid = 1'b1;
        in_word  = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_ready", 32'(in_ready), 32'd0);
            chk("hold_valid", 32'(msg_valid), 32'd1);
        end
        check_sched("hold");
        // Release together with a word: word must not be taken.
        msg_release = 1'b1;
        @(posedge clk);
        #1;
        msg_release = 1'b0;
        in_valid    = 1'b0;
        in_word     = 32'd0;
        chk("relw_ready", 32'(in_ready), 32'd1);
        chk("relw_valid", 32'(msg_valid), 32'd0);
        chk("relw_w0", msg[0], exp_w[0]);
        rand_block();
        run_block("afterrel", 16'h0000);
        release_now();

        // Reset in the middle of EXPAND (t = 40).
        rand_block();
        build_model();
        load_block(16'h0000, t0a, t15a);
        repeat (24) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("mrst_valid", 32'(msg_valid), 32'd0);
        chk("mrst_ready", 32'(in_ready), 32'd1);
        for (int t = 0; t < 80; t++) chk($sformatf("mrst_w%0d", t), msg[t], 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        abc_block();
        run_block("reabc", 16'h0000);
        release_now();

        // Back-to-back blocks with release on the first HOLD cycle.
        rand_block();
        build_model();
        load_block(16'h0000, t0a, t15a);
        wait_valid(t15a, "b2bA");
        check_sched("b2bA");
        release_now();
        chk("b2b_ready", 32'(in_ready), 32'd1);
        rand_block();
        build_model();
        load_block(16'h0000, t0b, t15b);
        chk("b2b_period", 32'((t0b - t0a) / 10), 32'd81);
        wait_valid(t15b, "b2bB");
        check_sched("b2bB");
        release_now();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
